// File: rtl/demux_pkg.sv
// demux_pkg: shared constants and select-width helper for the stream demultiplexer.
package demux_pkg;

    localparam int DROP_CNT_W = 8;

    function automatic int sel_w(input int ch);
        return (ch > 2) ? $clog2(ch) : 1;
    endfunction

endpackage

// File: rtl/demux_stream_slot.sv
// demux_stream_slot: one-entry output register; a load overrides a same-cycle drain.
module demux_stream_slot #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] data_in,
    input  logic             ready,
    output logic             valid,
    output logic [WIDTH-1:0] data
);

    logic             valid_d, valid_q;
    logic [WIDTH-1:0] data_d, data_q;

    always_comb begin
        valid_d = load | (valid_q & ~ready);
        data_d  = load ? data_in : data_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid = valid_q;
    assign data  = data_q;

endmodule

// File: rtl/demux_stream.sv
// demux_stream: registered 1-to-CH valid/ready demultiplexer with broadcast and
// drop accounting for out-of-range selects.
module demux_stream
    import demux_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CH    = 8,
    parameter int SEL_W = sel_w(CH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WIDTH-1:0]      in_data,
    input  logic [SEL_W-1:0]      in_sel,
    input  logic                  in_bcast,
    output logic [CH-1:0]         out_valid,
    input  logic [CH-1:0]         out_ready,
    output logic [CH*WIDTH-1:0]   out_data,
    output logic                  err_sel,
    output logic [DROP_CNT_W-1:0] drop_cnt
);

    localparam int PAD = 1 << SEL_W;

    logic [CH-1:0]         free, load;
    logic [PAD-1:0]        free_pad;
    logic                  sel_ok, accept, err_d, err_q;
    logic [DROP_CNT_W-1:0] drop_d, drop_q;

    // Unused select codes read as free so an illegal word is always consumed.
    always_comb begin
        free     = ~out_valid | out_ready;
        free_pad = PAD'(free);
        sel_ok   = {1'b0, in_sel} < (SEL_W+1)'(CH);
        in_ready = !rst && (in_bcast ? &free : (!sel_ok || free_pad[in_sel]));
        accept   = in_valid && in_ready;
        load     = !accept ? '0 : in_bcast ? '1 : sel_ok ? CH'(1) << in_sel : '0;
        err_d    = accept && !in_bcast && !sel_ok;
        drop_d   = drop_q + DROP_CNT_W'(err_d && drop_q != '1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q  <= 1'b0;
            drop_q <= '0;
        end else begin
            err_q  <= err_d;
            drop_q <= drop_d;
        end
    end

    assign err_sel  = err_q;
    assign drop_cnt = drop_q;

    for (genvar k = 0; k < CH; k++) begin : g_slot
        demux_stream_slot #(.WIDTH(WIDTH)) u_slot (
            .clk     (clk),
            .rst     (rst),
            .load    (load[k]),
            .data_in (in_data),
            .ready   (out_ready[k]),
            .valid   (out_valid[k]),
            .data    (out_data[k*WIDTH +: WIDTH])
        );
    end

endmodule
